tea_job_ctrl: RTL
=================

// Module: tea_job_ctrl
// PURPOSE
//  Host-facing job sequencer for tea_cpu (TEA encrypt/decrypt firmware).
//  Accepts one job per valid/ready handshake: 64-bit block, 128-bit key and mode.
//  Owns the 32-byte IO mailbox that the CPU reaches through its io_* port, and holds
//  the CPU in reset while idle. Releases the CPU, waits for a firmware doorbell or a
//  watchdog timeout, then returns the block plus a status flag on a result handshake.
// PARAMETERS
//  TIMEOUT_CYCLES  20000   watchdog limit, in clk cycles spent in RUN
//  CNT_W           16      watchdog counter width; TIMEOUT_CYCLES must be < 2**CNT_W
//  DONE_ADDR       5'h19   doorbell IO address
//  MODE_ADDR       5'h18   mode byte IO address
// PORTS
//  clk         in   1    single clock
//  rst_n       in   1    asynchronous reset, active-low
//  job_valid   in   1    job offered
//  job_ready   out  1    job accepted when valid&&ready
//  job_mode    in   1    0 = encrypt, 1 = decrypt
//  job_data    in   64   v0 in [31:0], v1 in [63:32]
//  job_key     in   128  k0 in [31:0] .. k3 in [127:96]
//  res_valid   out  1    result available
//  res_ready   in   1    result consumed when valid&&ready
//  res_data    out  64   mailbox bytes 0x00..0x07 (byte n -> bits [8n+7:8n])
//  res_timeout out  1    1 = watchdog expired; res_data = mailbox contents at expiry
//  busy        out  1    state != IDLE
//  cpu_rst     out  1    tea_cpu rst (sync, active-high)
//  io_addr     in   5    from the CPU
//  io_rd       in   1    from the CPU
//  io_wr       in   1    from the CPU
//  io_wrdata   in   8    from the CPU
//  io_rddata   out  8    to the CPU, combinational
// BEHAVIOUR
//  Reset values: state IDLE, cpu_rst 1, job_ready 1, res_valid 0, res_timeout 0,
//   busy 0, mailbox all 0x00, watchdog 0.
//  Mailbox map: 0x00-07 data (LE), 0x08-17 key (LE), 0x18 mode {7'b0,mode},
//   0x19 doorbell (reads 0x00), 0x1A-1F unmapped (reads 0x00, writes ignored).
//  io_rddata = mailbox[io_addr], combinational; io_rd is not needed for the read.
//  State machine: IDLE -> RUN -> RESP -> IDLE.
//  IDLE: job_ready=1, cpu_rst=1. On the job_valid accept edge, load bytes 0x00-0x18,
//   clear the watchdog and go to RUN. cpu_rst is 0 from the next cycle (registered).
//  RUN: job_ready=0, cpu_rst=0. CPU writes land on the accept edge to any address
//   0x00-0x18. The CPU holds io_wr for two cycles; a repeated write is harmless.
//   The watchdog increments every RUN cycle.
//   Doorbell = io_wr && io_addr==DONE_ADDR && io_wrdata[0]: go to RESP, res_timeout=0.
//   Watchdog == TIMEOUT_CYCLES-1 with no doorbell: go to RESP, res_timeout=1.
//   Doorbell and expiry in the same cycle: the doorbell wins (res_timeout=0).
//  RESP: cpu_rst=1 (registered; asserted from the cycle after the RUN exit edge).
//   res_valid=1, with res_data and res_timeout stable until res_ready.
//   In RESP, CPU io_wr is ignored; the mailbox is frozen.
//   On the res_ready accept edge go to IDLE. A new job can be accepted the next cycle,
//   not in the same cycle.
//  Host job_valid outside IDLE is ignored (job_ready=0); no queueing.
//  Async reset mid-job: immediate return to reset values. The result is lost and the
//   CPU is held in reset.
//  Watchdog saturates and never wraps; CNT_W bits, unsigned.
// STRUCTURE
//  tea_io_map.vh (shared include): DONE_ADDR/MODE_ADDR/data and key base constants,
//   state encodings (IDLE=2'd0, RUN=2'd1, RESP=2'd2).
//  Sub-module tea_mailbox: 32x8 flops, async clear.
//   Bulk-load port (host, 25 bytes) has priority over the byte write port (CPU).
//   Provides a combinational read port and a 64-bit result tap.
//  tea_job_ctrl: FSM, watchdog, handshakes, cpu_rst register.
// TESTING
//  1 Reset: rst_n=0 -> cpu_rst=1, job_ready=1, res_valid=0, io_rddata=0x00 at every addr.
//  2 Accept: job data=64'h0123456789ABCDEF, key=0, mode=1 -> io_rddata@0x00=0xEF,
//    @0x07=0x01, @0x18=0x01; cpu_rst=0 one cycle later.
//  3 Doorbell: in RUN, CPU writes 0x5A to 0x03, then 0x01 to 0x19
//    -> res_valid=1, res_data[31:24]=0x5A, res_timeout=0; hold res_ready=0 for 10
//    cycles -> outputs stable, cpu_rst=1.
//  4 Timeout: TIMEOUT_CYCLES=50, no doorbell -> res_valid on RUN cycle 50,
//    res_timeout=1; doorbell and expiry in the same cycle -> res_timeout=0.
//  5 Back-to-back: job_valid held high -> second accept exactly 1 cycle after the
//    res handshake; job_valid while busy -> no accept.
//  6 Mid-job reset: rst_n pulsed low in RUN -> all outputs at reset values, mailbox 0.
//  End-to-end: with tea_cpu + TEA firmware, result matches the C reference model.

Source files
------------

// File: rtl/tea_job_ctrl_pkg.sv
// Shared constants, state encoding and mailbox helpers for the TEA job sequencer.
package tea_job_ctrl_pkg;

  // IO mailbox map: data bytes 0x00-0x07, key bytes 0x08-0x17, mode 0x18, doorbell 0x19.
  localparam logic [4:0] DATA_BASE   = 5'h00;
  localparam logic [4:0] KEY_BASE    = 5'h08;
  localparam logic [4:0] MODE_ADDR   = 5'h18;
  localparam logic [4:0] DONE_ADDR   = 5'h19;

  // Only bytes 0x00..0x18 are backed by storage; everything above reads as zero.
  localparam int         MBOX_BYTES  = 25;
  localparam int         LOAD_W      = 8 * MBOX_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Pack a host job into the mailbox image, byte n at bits [8n+7:8n].
  function automatic logic [LOAD_W-1:0] pack_load(input logic         mode,
                                                  input logic [127:0] key,
                                                  input logic [63:0]  data);
    return {7'd0, mode, key, data};
  endfunction

  // True for addresses that have storage behind them (data, key, mode).
  function automatic logic is_mapped(input logic [4:0] addr);
    return (addr >= DATA_BASE) && (addr <= MODE_ADDR);
  endfunction

  // True for addresses inside the key window.
  function automatic logic is_key(input logic [4:0] addr);
    return (addr >= KEY_BASE) && (addr < MODE_ADDR);
  endfunction

endpackage

// File: rtl/tea_job_ctrl_mailbox.sv
// Byte-wide IO mailbox shared between the host job port and the CPU io_* port.
// Host bulk load has priority over the CPU byte write; reads are combinational.
module tea_job_ctrl_mailbox
  import tea_job_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [LOAD_W-1:0] load_data,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [4:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic [63:0]       res_tap
);

  logic [7:0] mem_r [MBOX_BYTES];
  logic       wr_hit_s;
  logic       rd_hit_s;

  assign wr_hit_s = wr_en && is_mapped(wr_addr);
  assign rd_hit_s = is_mapped(rd_addr);

  // Mailbox storage: async clear, host bulk load first, then CPU byte writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MBOX_BYTES; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (load_en) begin
      for (int i = 0; i < MBOX_BYTES; i++) begin
        mem_r[i] <= load_data[8*i +: 8];
      end
    end else if (wr_hit_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // CPU read port: unmapped addresses (doorbell and 0x1A-0x1F) read as zero.
  always_comb begin
    rd_data = 8'h00;
    if (rd_hit_s) begin
      rd_data = mem_r[rd_addr];
    end else begin
      rd_data = 8'h00;
    end
  end

  // Result tap is simply the data window, byte 0 in the low bits.
  for (genvar g = 0; g < 8; g++) begin : g_tap
    assign res_tap[8*g +: 8] = mem_r[g];
  end

endmodule

// File: rtl/tea_job_ctrl.sv
// Host-facing job sequencer for tea_cpu: accepts a job, loads the mailbox,
// releases the CPU, waits for the doorbell or watchdog, then hands back the result.
module tea_job_ctrl
  import tea_job_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNT_W          = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic         job_mode,
  input  logic [63:0]  job_data,
  input  logic [127:0] job_key,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [63:0]  res_data,
  output logic         res_timeout,
  output logic         busy,
  output logic         cpu_rst,
  input  logic [4:0]   io_addr,
  input  logic         io_rd,
  input  logic         io_wr,
  input  logic [7:0]   io_wrdata,
  output logic [7:0]   io_rddata
);

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WDOG_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  wdog_r;
  logic              cpu_rst_r;
  logic              job_ready_r;
  logic              res_valid_r;
  logic              busy_r;
  logic              res_timeout_r;
  logic              timeout_s;
  logic              accept_s;
  logic              cpu_wr_s;
  logic              doorbell_s;
  logic              expire_s;
  logic              unused_s;

  // Reads need no strobe: the mailbox read port is purely combinational.
  assign unused_s   = io_rd;

  assign accept_s   = (state_r == ST_IDLE) && job_valid;
  assign cpu_wr_s   = (state_r == ST_RUN) && io_wr;
  assign doorbell_s = cpu_wr_s && (io_addr == DONE_ADDR) && io_wrdata[0];
  assign expire_s   = (state_r == ST_RUN) && (wdog_r == WDOG_LAST);

  // Next-state logic; the doorbell is checked first so it wins over expiry.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (job_valid) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (doorbell_s) begin
          state_s   = ST_RESP;
          timeout_s = 1'b0;
        end else if (expire_s) begin
          state_s   = ST_RESP;
          timeout_s = 1'b1;
        end else begin
          state_s   = ST_RUN;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered handshake/status outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      job_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      cpu_rst_r   <= 1'b1;
    end else begin
      state_r     <= state_s;
      job_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      res_valid_r <= (state_s == ST_RESP);
      cpu_rst_r   <= (state_s != ST_RUN);
    end
  end

  // Timeout flag: captured on the RUN exit edge, held through RESP, cleared afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_timeout_r <= 1'b0;
    end else if ((state_r == ST_RUN) && (state_s == ST_RESP)) begin
      res_timeout_r <= timeout_s;
    end else if (state_s != ST_RESP) begin
      res_timeout_r <= 1'b0;
    end
  end

  // Watchdog: cleared on job accept, counts every RUN cycle, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      wdog_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_RUN) && (wdog_r != WDOG_MAX)) begin
      wdog_r <= wdog_r + WDOG_ONE;
    end
  end

  tea_job_ctrl_mailbox u_mailbox (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (accept_s),
    .load_data (pack_load(job_mode, job_key, job_data)),
    .wr_en     (cpu_wr_s),
    .wr_addr   (io_addr),
    .wr_data   (io_wrdata),
    .rd_addr   (io_addr),
    .rd_data   (io_rddata),
    .res_tap   (res_data)
  );

  assign job_ready   = job_ready_r;
  assign busy        = busy_r;
  assign res_valid   = res_valid_r;
  assign res_timeout = res_timeout_r;
  assign cpu_rst     = cpu_rst_r;

endmodule
